// File: rtl/jbuffer_pkg.sv
// jbuffer_pkg: shared constants and helpers for the jbuffer cell.
//   clog2          - ceiling log2, used to size the fill counter
//   fill_cnt_width - fill counter width, never less than one bit
//   params_legal   - 1 when a WIDTH/STAGES pair is a legal configuration
//   RESET_BIT_DEFAULT - bit replicated to build the default stage reset value
package jbuffer_pkg;

    localparam logic RESET_BIT_DEFAULT = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    // The counter must hold 0..stages inclusive; keep one bit minimum so the
    // declaration stays legal even in the combinational configuration.
    function automatic int fill_cnt_width(input int stages);
        int w;
        w = clog2(stages + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (width >= 1) && (stages >= 0);
    endfunction

endpackage

// File: rtl/jbuffer_stage.sv
// jbuffer_stage: one WIDTH-bit register of the buffer chain.
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, loads RESET_VAL, beats en
//   en    - load d when high, hold when low
//   d     - stage input
//   q     - stage output
module jbuffer_stage
    import jbuffer_pkg::*;
#(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{RESET_BIT_DEFAULT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/jbuffer.sv
// jbuffer: non-inverting buffer cell, optionally pipelined.
//   a      - data in (WIDTH bits)
//   y      - data out, same polarity as a
//   clk    - rising-edge clock, unused when STAGES=0
//   rst    - synchronous active-high reset, unused when STAGES=0
//   en     - stage advance enable, unused when STAGES=0
//   y_vld  - high once y carries data accepted since the last reset
// STAGES=0 gives a plain wire (y_vld tied high). STAGES>=1 inserts a chain
// of enabled registers plus a saturating fill counter driving y_vld.
module jbuffer
    import jbuffer_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{RESET_BIT_DEFAULT}}
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             y_vld
);

    if (!params_legal(WIDTH, STAGES)) begin : g_illegal
        $error("jbuffer: illegal parameters WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    if (STAGES == 0) begin : g_comb
        assign y     = a;
        assign y_vld = 1'b1;

        // Control inputs are legitimately unconnected in this configuration.
        logic unused_inputs;
        assign unused_inputs = &{1'b0, clk, rst, en};
    end else begin : g_pipe
        localparam int CNT_W = fill_cnt_width(STAGES);
        localparam logic [CNT_W-1:0] FULL = CNT_W'(STAGES);

        // chain[0] is the input, chain[i+1] is the output of stage i.
        logic [WIDTH-1:0] chain [STAGES+1];
        logic [CNT_W-1:0] fill;

        assign chain[0] = a;

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            jbuffer_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (en),
                .d   (chain[i]),
                .q   (chain[i+1])
            );
        end

        // Counts enabled edges since reset and parks at STAGES, at which
        // point the last stage holds data that really came from a.
        always_ff @(posedge clk) begin
            if (rst) begin
                fill <= '0;
            end else if (en && (fill != FULL)) begin
                fill <= fill + CNT_W'(1);
            end
        end

        assign y     = chain[STAGES];
        assign y_vld = (fill == FULL);
    end

endmodule

// File: tb/tb_jbuffer.sv
module tb_jbuffer;

    localparam int NST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;

    // Combinational instance, default parameters.
    logic       a0 = 1'b0;
    logic       y0;
    logic       v0;

    // Pipelined instances share stimulus, differ only in reset value.
    logic [7:0] a  = 8'h00;
    logic [7:0] y1, y2;
    logic       v1, v2;

    int total = 0;
    int bad   = 0;

    // Reference model: values accepted since the last reset, keeping only
    // the most recent NST. Output is the oldest of those once NST exist.
    logic [7:0] hist [$];

    always #5 clk = ~clk;

    jbuffer u0 (
        .a     (a0),
        .y     (y0),
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .y_vld (v0)
    );

    jbuffer #(.WIDTH(8), .STAGES(NST)) u1 (
        .a     (a),
        .y     (y1),
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .y_vld (v1)
    );

    jbuffer #(.WIDTH(8), .STAGES(NST), .RESET_VAL(8'hA5)) u2 (
        .a     (a),
        .y     (y2),
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .y_vld (v2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_y(input logic [7:0] rv);
        return (hist.size() >= NST) ? hist[0] : rv;
    endfunction

    function automatic logic model_vld();
        return hist.size() >= NST;
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, then check
    // both pipelined instances shortly after the edge.
    task automatic tick(input logic r, input logic e, input logic [7:0] d);
        rst = r;
        en  = e;
        a   = d;
        @(posedge clk);
        if (r) begin
            hist.delete();
        end else if (e) begin
            hist.push_back(d);
            if (hist.size() > NST) void'(hist.pop_front());
        end
        #1;
        check("y_rv00",  y1, model_y(8'h00));
        check("vld_rv00", {7'b0, v1}, {7'b0, model_vld()});
        check("y_rva5",  y2, model_y(8'hA5));
        check("vld_rva5", {7'b0, v2}, {7'b0, model_vld()});
    endtask

    initial begin
        int two;
        two = 2;

        // Combinational pass-through
        a0 = 1'b0; #100;
        check("comb_y0", {7'b0, y0}, 8'h00);
        check("comb_vld", {7'b0, v0}, 8'h01);
        a0 = 1'b1; #100;
        check("comb_y1", {7'b0, y0}, 8'h01);
        a0 = 1'(two); #1;
        check("comb_trunc", {7'b0, y0}, 8'h00);
        a0 = 1'b1; #1;
        check("comb_back1", {7'b0, y0}, 8'h01);

        // Reset with en high: reset must win
        @(posedge clk); #1;
        tick(1'b1, 1'b1, 8'hEE);
        check("rst_y_00", y1, 8'h00);
        check("rst_y_a5", y2, 8'hA5);
        check("rst_vld", {7'b0, v1}, 8'h00);

        // Fill: 11,22,33 then first output appears
        tick(1'b0, 1'b1, 8'h11);
        tick(1'b0, 1'b1, 8'h22);
        tick(1'b0, 1'b1, 8'h33);
        check("fill_first", y1, 8'h11);
        check("fill_vld",   {7'b0, v1}, 8'h01);
        tick(1'b0, 1'b1, 8'h44);
        check("fill_second", y1, 8'h22);
        tick(1'b0, 1'b1, 8'h55);
        tick(1'b0, 1'b1, 8'h66);
        check("fill_fourth", y1, 8'h44);

        // Stall: four edges with en low while a changes
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 8'($urandom));
        check("stall_hold", y1, 8'h44);
        tick(1'b0, 1'b1, 8'h77);
        check("resume", y1, 8'h55);
        tick(1'b0, 1'b1, 8'h88);
        check("resume2", y1, 8'h66);

        // Mid-stream reset with en low
        tick(1'b1, 1'b0, 8'h99);
        check("mid_rst_y", y2, 8'hA5);
        check("mid_rst_vld", {7'b0, v2}, 8'h00);
        tick(1'b0, 1'b1, 8'hC1);
        tick(1'b0, 1'b0, 8'hC2);
        tick(1'b0, 1'b1, 8'hC3);
        check("refill_2", {7'b0, v2}, 8'h00);
        tick(1'b0, 1'b1, 8'hC4);
        check("refill_3_vld", {7'b0, v2}, 8'h01);
        check("refill_3_y", y2, 8'hC1);

        // Random traffic with occasional stalls and resets
        for (int k = 0; k < 300; k++) begin
            tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
